// File: rtl/ha_pkg.sv
// Shared definitions for the serial adder: FSM state encoding, default
// geometry and the step-count helper used to size the sequencing counter.
package ha_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 1;

    // Number of digit-wide add cycles needed to cover a full operand.
    function automatic int steps_f(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/ha_digit_add.sv
// Combinational DIGIT-bit ripple adder built from chained half-adder pairs
// (one full-adder cell per bit). Reused every cycle by ha_serial_adder.
//
// Ports:
//   a_d, b_d  in   DIGIT-bit operand slices
//   c_in      in   carry into bit 0
//   s_d       out  DIGIT-bit sum slice
//   c_out     out  carry out of the top bit
//   c_msb_in  out  carry into the top bit (signed overflow detection)
module ha_digit_add #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] p;
    logic [DIGIT-1:0] g;

    always_comb begin
        c    = '0;
        p    = '0;
        g    = '0;
        s_d  = '0;
        c[0] = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            // first half adder: propagate/generate of the operand bits
            p[i]     = a_d[i] ^ b_d[i];
            g[i]     = a_d[i] & b_d[i];
            // second half adder folds in the incoming carry
            s_d[i]   = p[i] ^ c[i];
            c[i + 1] = g[i] | (p[i] & c[i]);
        end
    end

    assign c_out    = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/ha_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one DIGIT-wide adder cell over
// WIDTH/DIGIT cycles, with valid/ready handshakes on input and output.
//
// Optional feature macro: ADDER_SUB_EN -- when defined, op=1 selects
// a - b (B inverted at load, initial carry forced to 1). When undefined,
// op is ignored and the block always adds.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, cin, op)
//   out_valid / out_ready result handshake (sum, cout, ovf)
//   busy                 high whenever the FSM is not idle
module ha_serial_adder
    import ha_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = steps_f(WIDTH, DIGIT);
    localparam int CNT_W = $clog2(STEPS + 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("ha_serial_adder: WIDTH must be at least 2");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("ha_serial_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   b_load;
    logic               c_load;
    logic [DIGIT-1:0]   dig_s;
    logic               dig_cout;
    logic               dig_cmsb;

`ifdef ADDER_SUB_EN
    // a - b == a + ~b + 1; cin is ignored for subtraction
    assign b_load = op ? ~b : b;
    assign c_load = op ? 1'b1 : cin;
`else
    logic unused_op;
    assign b_load    = b;
    assign c_load    = cin;
    assign unused_op = op;
`endif

    ha_digit_add #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d      (a_sh_q[DIGIT-1:0]),
        .b_d      (b_sh_q[DIGIT-1:0]),
        .c_in     (carry_q),
        .s_d      (dig_s),
        .c_out    (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                // new digit enters at the top; after STEPS shifts the
                // first digit has reached bit 0
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    cout_d  = dig_cout;
                    ovf_d   = dig_cout ^ dig_cmsb;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // handshake flags follow the next state so they are true flops
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ha_serial_adder.sv
// Directed bench for ha_serial_adder: one DIGIT=1 and one DIGIT=2 instance,
// WIDTH=8. Expected values are hand-computed constants.
module tb_ha_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       in_valid1, in_ready1, cin1, op1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [7:0] a1, b1, sum1;
    logic       in_valid2, in_ready2, cin2, op2, out_valid2, out_ready2, cout2, ovf2, busy2;
    logic [7:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;

    ha_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .op(op1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    ha_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .op(op2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2)
    );

    // Drive one operation into dut1 from IDLE; lat counts edges from the
    // cycle in_valid is raised until out_valid is seen (40 = timed out).
    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic op,
                        output int lat, output logic [7:0] s, output logic co, output logic ov);
        @(posedge clk); #1;
        a1 = a; b1 = b; cin1 = cin; op1 = op; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (out_valid1 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum1; co = cout1; ov = ovf1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
    endtask

    task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat, output logic [7:0] s, output logic co, output logic ov);
        @(posedge clk); #1;
        a2 = a; b2 = b; cin2 = cin; op2 = 1'b0; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 1;
        while (out_valid2 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum2; co = cout2; ov = ovf2;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a1 = 8'hAA; b1 = 8'h55; in_valid1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
        checks++; if (sum1 !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum1); end
        checks++; if ({cout1, ovf1} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf got %b want 00", {cout1, ovf1}); end
        checks++; if ({in_ready2, busy2} !== 2'b10) begin errors++; $display("FAIL reset_dut2 got %b want 10", {in_ready2, busy2}); end
        rst = 1'b0;
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_wins_capture busy got %b want 0", busy1); end
    endtask

    task automatic test_add_digit1();
        int lat; logic [7:0] s; logic co, ov;
        run1(8'h5A, 8'h3C, 1'b0, 1'b0, lat, s, co, ov);
        checks++; if (lat !== 9) begin errors++; $display("FAIL d1_latency got %0d want 9", lat); end
        checks++; if (s !== 8'h96) begin errors++; $display("FAIL d1_sum_5a_3c got %h want 96", s); end
        checks++; if ({co, ov} !== 2'b01) begin errors++; $display("FAIL d1_cout_ovf_5a_3c got %b want 01", {co, ov}); end
        run1(8'hFF, 8'h01, 1'b1, 1'b0, lat, s, co, ov);
        checks++; if (s !== 8'h01) begin errors++; $display("FAIL d1_sum_ff_01_c1 got %h want 01", s); end
        checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL d1_cout_ovf_ff_01_c1 got %b want 10", {co, ov}); end
    endtask

    task automatic test_add_digit2();
        int lat; logic [7:0] s; logic co, ov;
        run2(8'hFF, 8'h01, 1'b0, lat, s, co, ov);
        checks++; if (lat !== 5) begin errors++; $display("FAIL d2_latency got %0d want 5", lat); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL d2_sum_ff_01 got %h want 00", s); end
        checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL d2_cout_ovf_ff_01 got %b want 10", {co, ov}); end
        run2(8'h7F, 8'h00, 1'b1, lat, s, co, ov);
        checks++; if (s !== 8'h80) begin errors++; $display("FAIL d2_sum_7f_00_c1 got %h want 80", s); end
        checks++; if ({co, ov} !== 2'b01) begin errors++; $display("FAIL d2_cout_ovf_7f_00_c1 got %b want 01", {co, ov}); end
    endtask

    task automatic test_op();
        int lat; logic [7:0] s; logic co, ov;
        logic [7:0] exp_s1, exp_s2;
        logic [1:0] exp_f1, exp_f2;
`ifdef ADDER_SUB_EN
        exp_s1 = 8'hF0; exp_f1 = 2'b00;
        exp_s2 = 8'h7F; exp_f2 = 2'b11;
`else
        exp_s1 = 8'h30; exp_f1 = 2'b00;
        exp_s2 = 8'h81; exp_f2 = 2'b00;
`endif
        run1(8'h10, 8'h20, 1'b0, 1'b1, lat, s, co, ov);
        checks++; if (s !== exp_s1) begin errors++; $display("FAIL op_sum_10_20 got %h want %h", s, exp_s1); end
        checks++; if ({co, ov} !== exp_f1) begin errors++; $display("FAIL op_flags_10_20 got %b want %b", {co, ov}, exp_f1); end
        run1(8'h80, 8'h01, 1'b0, 1'b1, lat, s, co, ov);
        checks++; if (s !== exp_s2) begin errors++; $display("FAIL op_sum_80_01 got %h want %h", s, exp_s2); end
        checks++; if ({co, ov} !== exp_f2) begin errors++; $display("FAIL op_flags_80_01 got %b want %b", {co, ov}, exp_f2); end
    endtask

    task automatic test_backpressure();
        int n; logic rdy_seen;
        @(posedge clk); #1;
        a1 = 8'h11; b1 = 8'h22; cin1 = 1'b0; op1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        // second operand set held by the producer through RUN and DONE
        a1 = 8'h40; b1 = 8'h05;
        n = 1; rdy_seen = 1'b0;
        while (out_valid1 !== 1'b1 && n < 40) begin
            if (in_ready1 !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n !== 9) begin errors++; $display("FAIL bp_first_latency got %0d want 9", n); end
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL bp_in_ready_in_run got %b want 0", rdy_seen); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({sum1, cout1, ovf1} !== {8'h33, 2'b00}) begin errors++; $display("FAIL bp_hold_result cyc %0d got %h/%b%b want 33/00", i, sum1, cout1, ovf1); end
            checks++; if ({in_ready1, out_valid1} !== 2'b01) begin errors++; $display("FAIL bp_hold_flags cyc %0d got %b want 01", i, {in_ready1, out_valid1}); end
            @(posedge clk); #1;
        end
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        checks++; if ({in_ready1, out_valid1, busy1} !== 3'b100) begin errors++; $display("FAIL bp_after_handshake got %b want 100", {in_ready1, out_valid1, busy1}); end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checks++; if ({in_ready1, busy1} !== 2'b01) begin errors++; $display("FAIL bp_second_accept got %b want 01", {in_ready1, busy1}); end
        n = 0;
        while (out_valid1 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL bp_second_latency got %0d want 8", n); end
        checks++; if (sum1 !== 8'h45) begin errors++; $display("FAIL bp_second_sum got %h want 45", sum1); end
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        @(posedge clk); #1;
        a1 = 8'h01; b1 = 8'h01; cin1 = 1'b0; op1 = 1'b0;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        n = 0;
        while (out_valid1 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (out_valid1 !== 1'b1 && n < 40);
        in_valid1 = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL b2b_interval got %0d want 10", n); end
        checks++; if (sum1 !== 8'h02) begin errors++; $display("FAIL b2b_sum got %h want 02", sum1); end
        @(posedge clk); #1;
        out_ready1 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [7:0] s; logic co, ov;
        @(posedge clk); #1;
        a1 = 8'hFF; b1 = 8'hFF; cin1 = 1'b1; op1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({out_valid1, in_ready1, busy1} !== 3'b010) begin errors++; $display("FAIL midrun_flags got %b want 010", {out_valid1, in_ready1, busy1}); end
        checks++; if ({sum1, cout1, ovf1} !== 10'd0) begin errors++; $display("FAIL midrun_result got %h/%b%b want 00/00", sum1, cout1, ovf1); end
        run1(8'h01, 8'h02, 1'b0, 1'b0, lat, s, co, ov);
        checks++; if (lat !== 9) begin errors++; $display("FAIL midrun_new_latency got %0d want 9", lat); end
        checks++; if (s !== 8'h03) begin errors++; $display("FAIL midrun_new_sum got %h want 03", s); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; op1 = 1'b0; out_ready1 = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; op2 = 1'b0; out_ready2 = 1'b0;
        test_reset();
        test_add_digit1();
        test_add_digit2();
        test_op();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ha_serial_adder.md
# ha_serial_adder

Parametrised multi-cycle adder that generalises the single-bit half-adder cell to WIDTH-bit operands processed DIGIT bits per clock, with carry-in, carry-out, signed overflow and a valid/ready handshake on both sides. Sits between the pin-level input registers and the output mux of the tile. It trades latency for area: one DIGIT-wide adder cell is reused across WIDTH/DIGIT cycles.

## Interface
- WIDTH, 8, operand/result width in bits; ≥2
- DIGIT, 1, bits added per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- op  in  1  0 = add, 1 = subtract (ignored unless ADDER_SUB_EN)
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- cout  out  1  carry-out (for subtract: 1 = no borrow)
- ovf  out  1  signed overflow
- busy  out  1  state != IDLE

## Operation
- STEPS = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid, the block loads a, b, cin and op into shift registers, clears the step counter, and goes to RUN.
- RUN: each edge adds the low DIGIT bits of A_sh, B_sh and the carry register. The DIGIT-bit result is shifted into the top of the sum register, A_sh and B_sh shift right by DIGIT, the carry register updates and the counter increments. On the edge where counter == STEPS-1, the FSM goes to DONE and latches cout and ovf.
- ovf = carry into the MSB XOR carry out of the MSB, captured on the final step.
- DONE: out_valid=1. sum/cout/ovf are held stable while out_ready=0. When out_ready=1, the FSM goes to IDLE.
- in_ready=0 in RUN and DONE. An operand presented then is not consumed and must be held by the producer.
- No same-cycle accept while in DONE. The next accept occurs at the earliest one cycle after the output handshake.
- All arithmetic is modulo 2^WIDTH. No saturation.
- Reset, at any time including mid-RUN or in DONE: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, internal registers=0. A partial result is discarded.
- in_valid and rst high in the same cycle: reset wins, and the operands are not captured.

## Timing
- Accept edge E0. Compute edges E1..E_STEPS. out_valid is high from the cycle after E_STEPS.
- Latency from accept to out_valid = STEPS+1 cycles. WIDTH=8, DIGIT=1 gives 9; DIGIT=4 gives 3.
- Throughput: one result per STEPS+2 cycles when out_ready is held high.
- Outputs are registered. There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- ADDER_SUB_EN defined:
  - op=1 inverts B at load and forces the initial carry to 1, ignoring cin, so sum = a − b.
  - cout=1 means no borrow. ovf is signed subtract overflow.
- ADDER_SUB_EN undefined:
  - op is ignored and the block always adds.
  - The B inversion logic is not generated.

## Structure
- Shared package ha_pkg:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH/DIGIT constants
  - STEPS computation function
- Sub-module ha_digit_add: combinational DIGIT-bit ripple of half/full-adder cells.
  - Inputs: a_d, b_d, c_in.
  - Outputs: s_d, c_out, c_msb_in (carry into the top bit, used for ovf).
- Top module: FSM, counter, shift registers, handshake.

## Test plan
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, ovf=1, out_valid exactly 9 cycles after accept.
- WIDTH=8, DIGIT=2: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0, latency 5. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, ovf=1.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> sum, cout and ovf stable and in_ready=0 throughout. A second in_valid pulse during RUN/DONE is not consumed until one cycle after the output handshake.
- Reset mid-RUN: assert rst at step 3 of 8 -> next cycle out_valid=0, sum=0, in_ready=1, busy=0. A new accept a=0x01, b=0x02 gives 0x03.
- ADDER_SUB_EN, WIDTH=8: op=1, a=0x10, b=0x20 -> sum=0xF0, cout=0. Then a=0x80, b=0x01 -> sum=0x7F, ovf=1, cout=1.
- Without ADDER_SUB_EN: op=1, a=0x10, b=0x20, cin=0 -> sum=0x30 (op ignored).
